// File: rtl/reg_file_scoreboard_pkg.sv
// Shared constants, read-source encoding and the pending-counter width helper
// for the decode-stage register file and scoreboard.
package reg_file_scoreboard_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned REG_ZERO       = 0;
  localparam int unsigned REG_RA         = 31;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_LINK,
    SRC_WB,
    SRC_STORE
  } rd_src_e;

  function automatic int unsigned pend_cnt_width(input int unsigned max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/reg_file_scoreboard_pending_counter.sv
// Saturating up/down count of in-flight writers for one destination.
module pending_counter
  import reg_file_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 3,
  parameter int unsigned CNT_WIDTH   = pend_cnt_width(MAX_PENDING)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 nonzero
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (count_q != CNT_WIDTH'(MAX_PENDING)) count_d = count_q + CNT_WIDTH'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count   = count_q;
  assign full    = (count_q == CNT_WIDTH'(MAX_PENDING));
  assign nonzero = (count_q != '0);

endmodule

// File: rtl/reg_file_scoreboard.sv
// Decode-stage register file: multi-port bypassed reads, HI/LO, link write and
// a per-register pending-writer scoreboard that produces the decode stall.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned MAX_PENDING = 3,
  parameter int unsigned RA_ID       = REG_RA
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_id,
  output logic [READ_PORTS*DATA_WIDTH-1:0] rd_value,
  output logic [READ_PORTS-1:0]            rd_pending,
  input  logic                             issue_valid,
  input  logic [ADDR_WIDTH-1:0]            issue_dest_id,
  input  logic                             issue_hilo,
  input  logic                             wb_valid,
  input  logic [ADDR_WIDTH-1:0]            wb_id,
  input  logic [DATA_WIDTH-1:0]            wb_value,
  input  logic                             hilo_wb_valid,
  input  logic [DATA_WIDTH-1:0]            hi_wb,
  input  logic [DATA_WIDTH-1:0]            lo_wb,
  input  logic                             ra_write,
  input  logic [DATA_WIDTH-1:0]            ra_value,
  input  logic                             flush,
  output logic [DATA_WIDTH-1:0]            hi_value,
  output logic [DATA_WIDTH-1:0]            lo_value,
  output logic                             hilo_pending,
  output logic                             stall
);

  localparam int unsigned CW = pend_cnt_width(MAX_PENDING);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [CW-1:0]         reg_cnt  [NUM_REGS];
  logic [NUM_REGS-1:0]   reg_full, reg_nz, reg_inc, reg_dec;
  logic [CW-1:0]         hilo_cnt;
  logic                  hilo_full, hilo_nz;

  logic [ADDR_WIDTH-1:0] port_id  [READ_PORTS];
  logic [DATA_WIDTH-1:0] port_mem [READ_PORTS];
  rd_src_e               port_src [READ_PORTS];
  logic                  dest_blocked, issue_acc;

  assign reg_cnt[0]  = '0;
  assign reg_full[0] = 1'b0;
  assign reg_nz[0]   = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    pending_counter #(.MAX_PENDING(MAX_PENDING), .CNT_WIDTH(CW)) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (reg_inc[g]),
      .dec     (reg_dec[g]),
      .clear   (flush),
      .count   (reg_cnt[g]),
      .full    (reg_full[g]),
      .nonzero (reg_nz[g])
    );
  end

  pending_counter #(.MAX_PENDING(MAX_PENDING), .CNT_WIDTH(CW)) u_hilo_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (issue_hilo && !stall),
    .dec     (hilo_wb_valid),
    .clear   (flush),
    .count   (hilo_cnt),
    .full    (hilo_full),
    .nonzero (hilo_nz)
  );

  // A lone writer completing this cycle is not a hazard: its data comes via bypass.
  always_comb begin
    rd_value   = '0;
    rd_pending = '0;
    for (int unsigned k = 0; k < READ_PORTS; k++) begin
      port_id[k]  = rd_id[k*ADDR_WIDTH +: ADDR_WIDTH];
      port_mem[k] = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (port_id[k] == ADDR_WIDTH'(i)) begin
          port_mem[k]   = regs_q[i];
          rd_pending[k] = reg_nz[i] && !(reg_cnt[i] == CW'(1) && reg_dec[i]);
        end
      end
      if (port_id[k] == ADDR_WIDTH'(REG_ZERO))                 port_src[k] = SRC_ZERO;
      else if (ra_write && port_id[k] == ADDR_WIDTH'(RA_ID))   port_src[k] = SRC_LINK;
      else if (wb_valid && port_id[k] == wb_id)                port_src[k] = SRC_WB;
      else                                                     port_src[k] = SRC_STORE;
      case (port_src[k])
        SRC_ZERO: rd_value[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        SRC_LINK: rd_value[k*DATA_WIDTH +: DATA_WIDTH] = ra_value;
        SRC_WB:   rd_value[k*DATA_WIDTH +: DATA_WIDTH] = wb_value;
        default:  rd_value[k*DATA_WIDTH +: DATA_WIDTH] = port_mem[k];
      endcase
    end
  end

  always_comb begin
    reg_dec      = '0;
    dest_blocked = 1'b0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      reg_dec[i] = wb_valid && (wb_id == ADDR_WIDTH'(i));
      if (issue_dest_id == ADDR_WIDTH'(i)) dest_blocked = reg_full[i] && !reg_dec[i];
    end
    stall = (|rd_pending)
          || (issue_valid && dest_blocked)
          || (issue_hilo && hilo_full && !hilo_wb_valid);
  end

  always_comb begin
    issue_acc = issue_valid && !stall;
    reg_inc   = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      reg_inc[i] = issue_acc && (issue_dest_id == ADDR_WIDTH'(i));
    end
  end

  assign hilo_pending = hilo_nz && !(hilo_cnt == CW'(1) && hilo_wb_valid);
  assign hi_value     = hilo_wb_valid ? hi_wb : hi_q;
  assign lo_value     = hilo_wb_valid ? lo_wb : lo_q;

  // Link write is applied after writeback so the younger instruction wins RA.
  always_comb begin
    regs_d = regs_q;
    hi_d   = hilo_wb_valid ? hi_wb : hi_q;
    lo_d   = hilo_wb_valid ? lo_wb : lo_q;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (reg_dec[i]) regs_d[i] = wb_value;
    end
    if (ra_write) regs_d[RA_ID] = ra_value;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      regs_q <= regs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: directed vector table, mid-cycle reset sequence
// and randomized traffic against a behavioural model.
module tb_reg_file_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  rd_id;
  logic [63:0] rd_value;
  logic [1:0]  rd_pending;
  logic        issue_valid, issue_hilo, wb_valid, hilo_wb_valid, ra_write, flush;
  logic [4:0]  issue_dest_id, wb_id;
  logic [31:0] wb_value, hi_wb, lo_wb, ra_value, hi_value, lo_value;
  logic        hilo_pending, stall;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  reg_file_scoreboard #(
    .DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5),
    .READ_PORTS(2), .MAX_PENDING(3), .RA_ID(31)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rd_id(rd_id), .rd_value(rd_value),
    .rd_pending(rd_pending), .issue_valid(issue_valid), .issue_dest_id(issue_dest_id),
    .issue_hilo(issue_hilo), .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .hilo_wb_valid(hilo_wb_valid), .hi_wb(hi_wb), .lo_wb(lo_wb), .ra_write(ra_write),
    .ra_value(ra_value), .flush(flush), .hi_value(hi_value), .lo_value(lo_value),
    .hilo_pending(hilo_pending), .stall(stall)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  int          m_h;
  logic [31:0] m_hi, m_lo;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_cnt[i] = 0; end
    m_h = 0; m_hi = '0; m_lo = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] id);
    if (id == 0) return '0;
    if (ra_write && id == 31) return ra_value;
    if (wb_valid && wb_id == id) return wb_value;
    return m_regs[id];
  endfunction

  function automatic logic m_pend(input logic [4:0] id);
    if (id == 0) return 1'b0;
    return (m_cnt[id] > 0) && !(m_cnt[id] == 1 && wb_valid && wb_id == id);
  endfunction

  function automatic logic m_stall();
    logic s;
    s = m_pend(rd_id[4:0]) || m_pend(rd_id[9:5]);
    if (issue_valid && issue_dest_id != 0 && m_cnt[issue_dest_id] == 3
        && !(wb_valid && wb_id == issue_dest_id)) s = 1'b1;
    if (issue_hilo && m_h == 3 && !hilo_wb_valid) s = 1'b1;
    return s;
  endfunction

  task automatic m_commit();
    logic s, up, dn;
    s = m_stall();
    if (wb_valid && wb_id != 0) m_regs[wb_id] = wb_value;
    if (ra_write) m_regs[31] = ra_value;
    if (hilo_wb_valid) begin m_hi = hi_wb; m_lo = lo_wb; end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_h = 0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        up = issue_valid && !s && issue_dest_id == 5'(i);
        dn = wb_valid && wb_id == 5'(i);
        if (up && !dn && m_cnt[i] < 3) m_cnt[i]++;
        else if (dn && !up && m_cnt[i] > 0) m_cnt[i]--;
      end
      up = issue_hilo && !s;
      if (up && !hilo_wb_valid && m_h < 3) m_h++;
      else if (hilo_wb_valid && !up && m_h > 0) m_h--;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("rd_value0", rd_value[31:0],  m_read(rd_id[4:0]));
    chk("rd_value1", rd_value[63:32], m_read(rd_id[9:5]));
    chk("rd_pending0", 32'(rd_pending[0]), 32'(m_pend(rd_id[4:0])));
    chk("rd_pending1", 32'(rd_pending[1]), 32'(m_pend(rd_id[9:5])));
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("hi_value", hi_value, hilo_wb_valid ? hi_wb : m_hi);
    chk("lo_value", lo_value, hilo_wb_valid ? lo_wb : m_lo);
    chk("hilo_pending", 32'(hilo_pending),
        32'((m_h > 0) && !(m_h == 1 && hilo_wb_valid)));
  endtask

  task automatic idle_inputs();
    rd_id = '0; issue_valid = 0; issue_dest_id = '0; issue_hilo = 0;
    wb_valid = 0; wb_id = '0; wb_value = '0; hilo_wb_valid = 0; hi_wb = '0; lo_wb = '0;
    ra_write = 0; ra_value = '0; flush = 0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic model_cycle();
    @(negedge clock);
    check_model();
    @(posedge clock);
    m_commit();
    #1;
  endtask

  typedef struct {
    logic [4:0]  rd0, rd1;
    logic        iv; logic [4:0] idest; logic ih;
    logic        wbv; logic [4:0] wbid; logic [31:0] wbval;
    logic        hwv; logic [31:0] hi, lo;
    logic        raw; logic [31:0] raval;
    logic        fl;
    logic [31:0] e_rd0; logic e_p0, e_p1, e_stall;
    logic [31:0] e_hi, e_lo; logic e_hp;
  } vec_t;

  function automatic logic [4:0] rid();
    int unsigned r;
    r = $urandom_range(0, 9);
    return (r == 9) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    vec_t tbl[$];
    // rd0 rd1 | iv dest ih | wbv id val | hwv hi lo | raw raval | fl || rd0 p0 p1 stall hi lo hp
    tbl.push_back('{5,0, 0,0,0, 1,5,'h1234, 0,0,0, 0,0, 0,  'h1234,0,0,0, 0,0,0});
    tbl.push_back('{5,0, 0,0,0, 0,0,0,      0,0,0, 0,0, 0,  'h1234,0,0,0, 0,0,0});
    tbl.push_back('{0,0, 0,0,0, 1,0,'hFFFF, 0,0,0, 0,0, 0,  0,0,0,0,      0,0,0});
    tbl.push_back('{0,0, 0,0,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      0,0,0});
    tbl.push_back('{0,0, 1,8,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      0,0,0});
    tbl.push_back('{0,0, 1,8,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      0,0,0});
    tbl.push_back('{0,0, 1,8,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      0,0,0});
    tbl.push_back('{0,0, 1,8,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,1,      0,0,0});
    tbl.push_back('{8,0, 0,0,0, 0,0,0,      0,0,0, 0,0, 0,  0,1,0,1,      0,0,0});
    tbl.push_back('{8,0, 0,0,0, 1,8,'h11,   0,0,0, 0,0, 0,  'h11,1,0,1,   0,0,0});
    tbl.push_back('{8,0, 0,0,0, 1,8,'h22,   0,0,0, 0,0, 0,  'h22,1,0,1,   0,0,0});
    tbl.push_back('{8,0, 0,0,0, 1,8,'h33,   0,0,0, 0,0, 0,  'h33,0,0,0,   0,0,0});
    tbl.push_back('{8,0, 0,0,0, 0,0,0,      0,0,0, 0,0, 0,  'h33,0,0,0,   0,0,0});
    tbl.push_back('{31,0, 0,0,0, 1,31,'hA,  0,0,0, 1,'hB, 0, 'hB,0,0,0,   0,0,0});
    tbl.push_back('{31,0, 0,0,0, 0,0,0,     0,0,0, 0,0, 0,  'hB,0,0,0,    0,0,0});
    tbl.push_back('{0,0, 0,0,1, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      0,0,0});
    tbl.push_back('{0,0, 0,0,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      0,0,1});
    tbl.push_back('{0,0, 0,0,0, 0,0,0,      1,7,3, 0,0, 0,  0,0,0,0,      7,3,0});
    tbl.push_back('{0,0, 0,0,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      7,3,0});
    tbl.push_back('{0,0, 1,4,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      7,3,0});
    tbl.push_back('{0,0, 1,9,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      7,3,0});
    tbl.push_back('{4,0, 0,0,0, 0,0,0,      0,0,0, 0,0, 1,  0,1,0,1,      7,3,0});
    tbl.push_back('{4,9, 0,0,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      7,3,0});
    tbl.push_back('{4,0, 0,0,0, 1,4,'h55,   0,0,0, 0,0, 0,  'h55,0,0,0,   7,3,0});
    tbl.push_back('{4,0, 0,0,0, 0,0,0,      0,0,0, 0,0, 0,  'h55,0,0,0,   7,3,0});
    tbl.push_back('{0,0, 1,6,0, 0,0,0,      0,0,0, 0,0, 1,  0,0,0,0,      7,3,0});
    tbl.push_back('{6,0, 0,0,0, 0,0,0,      0,0,0, 0,0, 0,  0,0,0,0,      7,3,0});

    idle_inputs();
    m_reset();
    reset_n = 1'b0;
    #3;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_hi", hi_value, 32'd0);
    chk("reset_lo", lo_value, 32'd0);
    chk("reset_hilo_pending", 32'(hilo_pending), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      rd_id = {tbl[i].rd1, tbl[i].rd0};
      issue_valid = tbl[i].iv; issue_dest_id = tbl[i].idest; issue_hilo = tbl[i].ih;
      wb_valid = tbl[i].wbv; wb_id = tbl[i].wbid; wb_value = tbl[i].wbval;
      hilo_wb_valid = tbl[i].hwv; hi_wb = tbl[i].hi; lo_wb = tbl[i].lo;
      ra_write = tbl[i].raw; ra_value = tbl[i].raval; flush = tbl[i].fl;
      @(negedge clock);
      chk($sformatf("vec%0d_rd0", i), rd_value[31:0], tbl[i].e_rd0);
      chk($sformatf("vec%0d_p0", i), 32'(rd_pending[0]), 32'(tbl[i].e_p0));
      chk($sformatf("vec%0d_p1", i), 32'(rd_pending[1]), 32'(tbl[i].e_p1));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d_hi", i), hi_value, tbl[i].e_hi);
      chk($sformatf("vec%0d_lo", i), lo_value, tbl[i].e_lo);
      chk($sformatf("vec%0d_hp", i), 32'(hilo_pending), 32'(tbl[i].e_hp));
      @(posedge clock);
      m_commit();
      #1;
    end

    // Mid-cycle reset with live counters and data
    idle_inputs();
    wb_valid = 1; wb_id = 5'd7; wb_value = 32'h99;
    issue_valid = 1; issue_dest_id = 5'd3;
    hilo_wb_valid = 1; hi_wb = 32'h5; lo_wb = 32'h6;
    model_cycle();
    idle_inputs();
    issue_hilo = 1;
    model_cycle();
    idle_inputs();
    rd_id = {5'd3, 5'd7};
    @(negedge clock);
    chk("pre_reset_rd0", rd_value[31:0], 32'h99);
    chk("pre_reset_p1", 32'(rd_pending[1]), 32'd1);
    chk("pre_reset_hp", 32'(hilo_pending), 32'd1);
    chk("pre_reset_hi", hi_value, 32'h5);
    @(posedge clock);
    m_commit();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_rd0", rd_value[31:0], 32'd0);
    chk("midreset_p1", 32'(rd_pending[1]), 32'd0);
    chk("midreset_stall", 32'(stall), 32'd0);
    chk("midreset_hi", hi_value, 32'd0);
    chk("midreset_lo", lo_value, 32'd0);
    chk("midreset_hp", 32'(hilo_pending), 32'd0);
    m_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      rd_id[4:0]    = ($urandom_range(0, 9) < 4) ? 5'd0 : rid();
      rd_id[9:5]    = ($urandom_range(0, 9) < 4) ? 5'd0 : rid();
      issue_valid   = ($urandom_range(0, 2) == 0);
      issue_dest_id = rid();
      issue_hilo    = ($urandom_range(0, 5) == 0);
      wb_valid      = ($urandom_range(0, 2) == 0);
      wb_id         = rid();
      wb_value      = $urandom;
      hilo_wb_valid = ($urandom_range(0, 5) == 0);
      hi_wb         = $urandom;
      lo_wb         = $urandom;
      ra_write      = ($urandom_range(0, 7) == 0);
      ra_value      = $urandom;
      flush         = ($urandom_range(0, 19) == 0);
      model_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Parametrised successor to the decode-stage register storage: general-purpose register file with N read ports, write-before-read bypass, HI/LO special registers and a per-register pending-write scoreboard.
- Sits in decode and feeds the operand read path and the hazard unit.
- Supports multiple in-flight long-latency writers (divide, loads) and generates its own stall.
- Handles the link (ra) write and pipeline flush.

Parameters:
- DATA_WIDTH, 32, width of every register and data port.
- NUM_REGS, 32, number of general registers; register 0 is hard-wired zero.
- ADDR_WIDTH, 5, register id width; must be >= clog2(NUM_REGS).
- READ_PORTS, 2, number of independent combinational read ports.
- MAX_PENDING, 3, maximum in-flight writes tracked per register; counter width is clog2(MAX_PENDING+1).
- RA_ID, 31, register written by the link port.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rd_id  in  READ_PORTS*ADDR_WIDTH  packed read ids; port k is at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_value  out  READ_PORTS*DATA_WIDTH  packed read data.
- rd_pending  out  READ_PORTS  port k reads a register with an outstanding writer.
- issue_valid  in  1  instruction in decode claims a destination.
- issue_dest_id  in  ADDR_WIDTH  claimed destination.
- issue_hilo  in  1  instruction in decode claims HI/LO (div/mult).
- wb_valid  in  1  writeback write enable.
- wb_id  in  ADDR_WIDTH  writeback destination.
- wb_value  in  DATA_WIDTH  writeback data.
- hilo_wb_valid  in  1  HI/LO writeback enable.
- hi_wb  in  DATA_WIDTH  HI writeback data.
- lo_wb  in  DATA_WIDTH  LO writeback data.
- ra_write  in  1  link write from the jump unit.
- ra_value  in  DATA_WIDTH  link value (pc_plus_four based).
- flush  in  1  discard all in-flight claims.
- hi_value  out  DATA_WIDTH  HI with bypass.
- lo_value  out  DATA_WIDTH  LO with bypass.
- hilo_pending  out  1  HI/LO has an outstanding writer.
- stall  out  1  decode must hold this cycle.

Behaviour:
Reset (asynchronous, on reset_n low):
- All registers, HI, LO and pending counters clear to 0.
- Outputs derived from these are therefore 0 and stall is 0.

Reads:
- Combinational, zero latency.
- rd_value = 0 if id = 0.
- Else ra_value if ra_write and id = RA_ID.
- Else wb_value if wb_valid and wb_id = id.
- Else stored value.
- hi_value / lo_value bypass hi_wb / lo_wb when hilo_wb_valid.
- Ids >= NUM_REGS read 0 and are never pending.

Writes:
- On the clock edge; storage is visible next cycle, bypass makes it visible the same cycle.
- Writes to register 0 are ignored.
- ra_write and wb_valid to RA_ID in the same cycle: ra_value is stored (younger instruction wins).

Scoreboard (per register, saturating counter 0..MAX_PENDING; a separate counter for HI/LO):
- Increment on an accepted issue to that id.
- Decrement on a wb to that id, floored at 0.
- Simultaneous accepted issue and wb to the same id: count unchanged.
- Register 0 is never counted.
- rd_pending[k] = count(id) > 0, except that when count = 1 and a wb to that id occurs this cycle, rd_pending[k] = 0 (data arrives via bypass).
- ra_write does not touch the counters.
- hilo_pending follows the same rules using issue_hilo / hilo_wb_valid.

Stall (combinational):
- stall = OR of rd_pending over all ports.
- OR issue_valid with count(issue_dest_id) = MAX_PENDING and no same-cycle wb to it.
- OR issue_hilo with the HI/LO counter full and no same-cycle hilo_wb_valid.
- Issue is accepted only when issue_valid and not stall; likewise for issue_hilo.

Flush:
- All counters clear to 0 on the next edge.
- Accepted issues in the flush cycle are dropped.
- Writes in the flush cycle still update data.
- Later wbs from flushed writers update data and decrement with floor at 0.

Reset mid-operation:
- Immediate clear; no write completes in that cycle.

Decomposition:
- Shared package holds:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - REG_ZERO = 0;
  - REG_RA = 31;
  - the pending-counter width function.
- Natural sub-module: pending_counter (one saturating up/down counter with inc, dec, clear, count, full, nonzero), instantiated NUM_REGS-1 times plus once for HI/LO.

Test Plan:
- Reset, then write wb_id=5 value 0x1234 while reading id 5 on port 0 -> rd_value = 0x1234 the same cycle and the next cycle; read of id 0 after wb_id=0 value 0xFFFF -> 0.
- issue_dest_id=8 three times (MAX_PENDING=3), then a 4th issue to 8 -> stall=1 and count stays 3; three wbs to 8 -> rd_pending on id 8 drops in the cycle of the 3rd wb and rd_value equals the 3rd wb_value.
- Same cycle wb_valid id 31 value 0xA, ra_write value 0xB -> next-cycle read of 31 = 0xB; read in the same cycle = 0xB.
- issue_hilo, then a read of HI -> hilo_pending=1; hilo_wb_valid hi=0x7 lo=0x3 -> hi_value=0x7 and lo_value=0x3 that cycle, hilo_pending=0.
- Issue to ids 4 and 9, then flush -> all rd_pending=0 and stall=0 next cycle; a late wb to 4 value 0x55 -> stored, counter stays 0.
- Assert reset_n low between clock edges with counters non-zero -> counters, HI, LO and registers read 0 immediately and stall=0.
